cursor_input_ctrl: RTL and testbench
====================================

Name: cursor_input_ctrl

Overview:
- Upstream stage of the board-cover state block: turns six raw push-buttons into a cursor position (x_coord, y_coord) and single-cycle flag/open command pulses.
- Synchronises and debounces every button, detects press edges and wraps the cursor at board edges.
- After each command, freezes the cursor for one full board scan so the command lands on the intended cell.

Parameters:
- x_size, 16, board width in cells
- y_size, 16, board height in cells
- x_coord_bits, 4, width of x_coord
- y_coord_bits, 4, width of y_coord
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (sim value 4)
- HOLD_CYCLES, 256, movement hold-off after a command pulse; must be >= x_size*y_size
- REPEAT_DELAY, 25000000, hold time before auto-repeat starts (CURSOR_AUTOREPEAT_EN only)
- REPEAT_PERIOD, 5000000, auto-repeat interval (CURSOR_AUTOREPEAT_EN only)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_up, btn_down, btn_left, btn_right  in  1 each  raw direction buttons, asynchronous, active-high
- btn_flag, btn_open  in  1 each  raw command buttons, asynchronous, active-high
- lock  in  1  game over; flag/open commands are discarded while high
- x_coord  out  x_coord_bits  cursor column
- y_coord  out  y_coord_bits  cursor row
- flag  out  1  one-cycle flag-toggle pulse
- open  out  1  one-cycle open pulse
- busy  out  1  high while the hold-off counter is non-zero

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high. While reset is high: x_coord=0, y_coord=0, flag=0, open=0, busy=0; all synchroniser flops, debounced levels, debounce counters and the hold-off counter are cleared. Reset mid-debounce discards any partial count.
- Per button:
  - 2-flop synchroniser, then debounce counter.
  - The counter clears whenever the synced level equals the debounced level, or when the synced level changes.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels differ, the debounced level takes the synced level.
  - Rising edge of the debounced level = press event, valid for one cycle. Release produces no event.
  - A button held through reset deassertion yields exactly one press event.
- Latency: a clean raw 0->1 transition that is stable from the first sampling edge produces the output change (coord update or pulse) exactly DEBOUNCE_CYCLES+3 rising edges later.
- Moves:
  - up: y-1, wraps 0 -> y_size-1.
  - down: y+1, wraps y_size-1 -> 0.
  - left/right: same rule on x with x_size.
  - Arithmetic is modulo board size, not 2^bits; non-power-of-two sizes must wrap correctly.
  - up+down events in the same cycle cancel (y unchanged); left+right likewise. Diagonal (up+left) applies both.
- Commands:
  - flag event -> flag=1 for exactly one cycle; open event -> open=1 for one cycle.
  - flag and open in the same cycle: flag wins, open is dropped.
  - When lock=1, flag and open events are dropped with no pulse.
- Hold-off:
  - An emitted pulse loads the hold-off counter with HOLD_CYCLES in the same cycle as the pulse.
  - While the counter is non-zero: busy=1, move events are discarded (not queued), and further flag/open events are discarded.
  - The counter decrements each cycle. Once it reaches 0, events are accepted in that same cycle.
  - A move event in the same cycle as an accepted command is discarded, so the command always targets the pre-move coordinate.
- Outputs are registered. x_coord and y_coord are stable except on accepted move cycles.

Optional Feature:
- CURSOR_AUTOREPEAT_EN defined:
  - A direction button held debounced-high for REPEAT_DELAY cycles after its press event generates an additional move event.
  - Further events follow every REPEAT_PERIOD cycles until release.
  - Repeat events obey the same cancel and hold-off rules.
  - Flag and open never repeat.
- Undefined: no repeat logic, and the REPEAT_* parameters are unused. Holding a button produces exactly one move.

Decomposition:
- Shared package:
  - button index constants (BTN_UP=0 .. BTN_OPEN=5), NUM_BTNS=6
  - command encoding matching board_cover's change_cell: CMD_NONE=2'b00, CMD_OPEN=2'b01, CMD_FLAG=2'b10
- Sub-module btn_debounce: synchroniser, debounce counter and rising-edge detect, with a DEBOUNCE_CYCLES parameter. Instantiated six times.
- The top level holds cursor arithmetic, command arbitration, hold-off and auto-repeat.

Test Plan:
- Reset, then press right once (DEBOUNCE_CYCLES=4) -> x_coord 0->1 exactly 7 edges after the press, y_coord=0, no flag/open.
- At x_coord=0, press left -> x_coord=15. With x_size=10 at x=9, press right -> x=0.
- Raw btn_open glitching at a period shorter than 4 cycles for 40 cycles, then low -> no open pulse, coords unchanged.
- Press flag and open together -> single flag pulse, no open, busy=1 for 256 cycles. A right press at cycle 100 of the hold-off is ignored (x unchanged); a right press at cycle 260 moves x.
- lock=1, press open -> no pulse, busy stays 0. Press down with lock=1 -> y increments.
- Assert reset mid-debounce of btn_up and during hold-off -> all outputs 0 immediately (asynchronous). After release, no spurious move. Up held through reset -> exactly one move.

Source files
------------

// File: rtl/cursor_input_ctrl_pkg.sv
// Shared definitions for the cursor input controller: button indices,
// the command encoding understood by board_cover's change_cell input,
// and the modulo-board-size cursor step used for both axes.
package cursor_input_ctrl_pkg;

  // Button slots in the packed button vectors.
  localparam int NUM_BTNS  = 6;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_FLAG  = 4;
  localparam int BTN_OPEN  = 5;

  // Number of direction buttons (they occupy the low slots).
  localparam int NUM_DIRS  = 4;

  // Command encoding shared with board_cover's change_cell.
  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_OPEN = 2'b01,
    CMD_FLAG = 2'b10
  } cmd_e;

  // One cursor step along an axis of 'size' cells. Opposing requests in the
  // same cycle cancel. Wrapping is modulo the board size, so boards that are
  // not a power of two wrap at the right cell rather than at 2^bits.
  function automatic int unsigned wrap_step(input int unsigned pos,
                                            input int unsigned size,
                                            input logic        inc,
                                            input logic        dec);
    int unsigned nxt;
    nxt = pos;
    if (inc && !dec) begin
      nxt = (pos == size - 32'd1) ? 32'd0 : pos + 32'd1;
    end else if (dec && !inc) begin
      nxt = (pos == 32'd0) ? size - 32'd1 : pos - 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/cursor_input_ctrl_btn_debounce.sv
// One push-button front end: two-flop synchroniser, stable-time debounce
// counter and a rising-edge detector on the debounced level. The press pulse
// lasts exactly one cycle; releases produce no pulse.
module btn_debounce
  import cursor_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic             level_q;
  logic             level_d;
  logic             level_prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count how long the synced level has disagreed with the accepted level.
  // A single-bit level that changes while disagreeing must come back into
  // agreement, so the equality test also covers "synced level changed".
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, debounce state and edge-detect history.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      meta_q       <= 1'b0;
      sync_q       <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
    end else begin
      meta_q       <= raw_i;
      sync_q       <= meta_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
    end
  end

  assign level_o = level_q;
  assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/cursor_input_ctrl.sv
// Cursor input controller: debounces six raw buttons, moves a wrapping cursor
// and issues one-cycle flag/open pulses. After every command pulse the cursor
// and further commands are frozen for HOLD_CYCLES so the command lands on the
// cell that was selected when it was issued.
// Optional build macro: CURSOR_AUTOREPEAT_EN enables auto-repeat of held
// direction buttons (REPEAT_DELAY, then every REPEAT_PERIOD cycles).
module cursor_input_ctrl
  import cursor_input_ctrl_pkg::*;
#(
  parameter int x_size          = 16,
  parameter int y_size          = 16,
  parameter int x_coord_bits    = 4,
  parameter int y_coord_bits    = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 256,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_flag,
  input  logic                    btn_open,
  input  logic                    lock,
  output logic [x_coord_bits-1:0] x_coord,
  output logic [y_coord_bits-1:0] y_coord,
  output logic                    flag,
  output logic                    open,
  output logic                    busy
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  logic [NUM_BTNS-1:0]     btn_raw;
  logic [NUM_BTNS-1:0]     btn_level;
  logic [NUM_BTNS-1:0]     btn_press;
  logic [NUM_DIRS-1:0]     move_ev;

  logic [x_coord_bits-1:0] x_q, x_d;
  logic [y_coord_bits-1:0] y_q, y_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic                    flag_q, open_q, busy_q;
  logic                    accept;
  logic                    move_ok;
  cmd_e                    cmd;

  assign btn_raw = {btn_open, btn_flag, btn_right, btn_left, btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (clk),
        .rst_i  (reset),
        .raw_i  (btn_raw[gi]),
        .level_o(btn_level[gi]),
        .press_o(btn_press[gi])
      );
    end
  endgenerate

`ifdef CURSOR_AUTOREPEAT_EN
  logic [NUM_DIRS-1:0] rep_fire;

  generate
    for (gi = 0; gi < NUM_DIRS; gi++) begin : g_repeat
      logic [31:0] rep_cnt_q;
      logic        rep_armed_q;

      // First repeat after REPEAT_DELAY cycles of hold, then one per period.
      assign rep_fire[gi] = btn_level[gi] & ~btn_press[gi] &
                            (rep_armed_q ? (rep_cnt_q == 32'(REPEAT_PERIOD - 1))
                                         : (rep_cnt_q == 32'(REPEAT_DELAY - 1)));

      // Hold timer restarts on each press and is idle while released.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          rep_cnt_q   <= '0;
          rep_armed_q <= 1'b0;
        end else if (!btn_level[gi] || btn_press[gi]) begin
          rep_cnt_q   <= '0;
          rep_armed_q <= 1'b0;
        end else if (rep_fire[gi]) begin
          rep_cnt_q   <= '0;
          rep_armed_q <= 1'b1;
        end else begin
          rep_cnt_q   <= rep_cnt_q + 32'd1;
        end
      end
    end
  endgenerate

  assign move_ev = btn_press[NUM_DIRS-1:0] | rep_fire;

  // Command buttons never repeat, so their levels have no consumer.
  logic unused_cmd_level;
  assign unused_cmd_level = ^btn_level[NUM_BTNS-1:NUM_DIRS];
`else
  assign move_ev = btn_press[NUM_DIRS-1:0];

  // Without auto-repeat the debounced levels and repeat timing are not needed.
  logic unused_cfg;
  assign unused_cfg = ^{btn_level, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  // Arbitrate commands, gate moves and compute the next cursor/hold-off state.
  always_comb begin
    accept = (hold_q == '0);
    cmd    = CMD_NONE;
    if (accept && !lock) begin
      if (btn_press[BTN_FLAG]) begin
        cmd = CMD_FLAG;
      end else if (btn_press[BTN_OPEN]) begin
        cmd = CMD_OPEN;
      end
    end

    // A move that coincides with an accepted command is dropped so the
    // command acts on the pre-move cell.
    move_ok = accept && (cmd == CMD_NONE);

    x_d = x_q;
    y_d = y_q;
    if (move_ok) begin
      x_d = x_coord_bits'(wrap_step(32'(x_q), x_size,
                                    move_ev[BTN_RIGHT], move_ev[BTN_LEFT]));
      y_d = y_coord_bits'(wrap_step(32'(y_q), y_size,
                                    move_ev[BTN_DOWN], move_ev[BTN_UP]));
    end

    if (cmd != CMD_NONE) begin
      hold_d = HOLD_W'(HOLD_CYCLES);
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end else begin
      hold_d = hold_q;
    end
  end

  // Registered cursor, command pulses, hold-off counter and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      hold_q <= '0;
      flag_q <= 1'b0;
      open_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      hold_q <= hold_d;
      flag_q <= (cmd == CMD_FLAG);
      open_q <= (cmd == CMD_OPEN);
      busy_q <= (hold_d != '0);
    end
  end

  assign x_coord = x_q;
  assign y_coord = y_q;
  assign flag    = flag_q;
  assign open    = open_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_cursor_input_ctrl.sv
// Self-checking bench for cursor_input_ctrl. Two instances (16x16 and 10x10
// boards) share the same button inputs and are compared every cycle against
// a behavioural model: a button is accepted once its raw level has been seen
// on D consecutive sampling edges (two edges of synchroniser delay), and the
// resulting press acts on the outputs one edge later.
module tb_cursor_input_ctrl;

  localparam int D    = 4;
  localparam int HOLD = 256;
  localparam int HL   = D + 2;

  logic clk = 1'b0;
  logic reset;
  logic btn_up, btn_down, btn_left, btn_right, btn_flag, btn_open;
  logic lock;

  logic [3:0] x16, y16, x10, y10;
  logic       flag16, open16, busy16, flag10, open10, busy10;

  always #5 clk = ~clk;

  cursor_input_ctrl #(
    .x_size(16), .y_size(16), .x_coord_bits(4), .y_coord_bits(4),
    .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(HOLD), .REPEAT_DELAY(40), .REPEAT_PERIOD(10)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_flag(btn_flag), .btn_open(btn_open), .lock(lock),
    .x_coord(x16), .y_coord(y16), .flag(flag16), .open(open16), .busy(busy16)
  );

  cursor_input_ctrl #(
    .x_size(10), .y_size(10), .x_coord_bits(4), .y_coord_bits(4),
    .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(HOLD), .REPEAT_DELAY(40), .REPEAT_PERIOD(10)
  ) dut10 (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_flag(btn_flag), .btn_open(btn_open), .lock(lock),
    .x_coord(x10), .y_coord(y10), .flag(flag10), .open(open10), .busy(busy10)
  );

  wire [21:0] obs_vec = {x16, y16, flag16, open16, busy16, x10, y10, flag10, open10, busy10};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int       mx[2];
  int       my[2];
  int       sz[2] = '{16, 10};
  int       hold;
  bit       ef, eo;
  bit [5:0] ev;
  bit       db[6];
  bit       hist[6][HL];

  function automatic logic [21:0] exp_vec();
    return {4'(mx[0]), 4'(my[0]), ef, eo, (hold != 0),
            4'(mx[1]), 4'(my[1]), ef, eo, (hold != 0)};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mx[k] = 0;
      my[k] = 0;
    end
    hold = 0; ef = 0; eo = 0; ev = '0;
    for (int b = 0; b < 6; b++) begin
      db[b] = 0;
      for (int i = 0; i < HL; i++) hist[b][i] = 0;
    end
  endtask

  task automatic model_step();
    bit [5:0] raw;
    bit [5:0] nev;
    bit       acc;
    bit       all_new;
    raw = {btn_open, btn_flag, btn_right, btn_left, btn_down, btn_up};
    // apply presses recognised on the previous edge
    acc = (hold == 0);
    ef  = acc && !lock && ev[4];
    eo  = acc && !lock && ev[5] && !ev[4];
    if (ef || eo) hold = HOLD;
    else if (hold > 0) hold--;
    if (acc && !ef && !eo) begin
      for (int k = 0; k < 2; k++) begin
        mx[k] = (mx[k] + int'(ev[3]) - int'(ev[2]) + sz[k]) % sz[k];
        my[k] = (my[k] + int'(ev[1]) - int'(ev[0]) + sz[k]) % sz[k];
      end
    end
    // debounce: new level once D consecutive samples (ending two edges ago) agree
    nev = '0;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < HL - 1; i++) hist[b][i] = hist[b][i+1];
      hist[b][HL-1] = raw[b];
      all_new = 1;
      for (int i = 0; i < D; i++) if (hist[b][i] == db[b]) all_new = 0;
      if (all_new) begin
        db[b]  = !db[b];
        nev[b] = db[b];
      end
    end
    ev = nev;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic set_btns(input bit [5:0] m);
    btn_up = m[0]; btn_down = m[1]; btn_left = m[2];
    btn_right = m[3]; btn_flag = m[4]; btn_open = m[5];
  endtask

  task automatic test_reset();
    reset = 1'b1; lock = 1'b0; set_btns(6'b0);
    repeat (3) cycle();
    n_checks++;
    if (obs_vec !== 22'd0) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected %h", obs_vec, 22'd0);
    end
    reset = 1'b0;
    repeat (2) begin
      cycle();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL reset_idle: got %h expected %h", obs_vec, exp_vec());
      end
    end
  endtask

  task automatic test_press_latency();
    set_btns(6'b001000);
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (i == 10) set_btns(6'b0);
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL latency_model i=%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
      if (i == 6) begin
        n_checks++;
        if (x16 !== 4'd0) begin
          n_errors++;
          $display("FAIL latency_early: x got %0d expected 0", x16);
        end
      end
      if (i == 7) begin
        n_checks++;
        if ({x16, y16, flag16, open16} !== {4'd1, 4'd0, 1'b0, 1'b0}) begin
          n_errors++;
          $display("FAIL latency_edge7: x=%0d y=%0d flag=%b open=%b expected x=1 y=0 no pulses",
                   x16, y16, flag16, open16);
        end
      end
    end
  endtask

  task automatic test_wrap();
    bit [5:0] masks [5] = '{6'b000100, 6'b000100, 6'b001000, 6'b000001, 6'b000010};
    int       ex16  [5] = '{0, 15, 0, 0, 0};
    int       ex10  [5] = '{0, 9, 0, 0, 0};
    int       ey16  [5] = '{0, 0, 0, 15, 0};
    int       ey10  [5] = '{0, 0, 0, 9, 0};
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 20; i++) begin
        set_btns(i < 10 ? masks[p] : 6'b0);
        cycle();
        n_checks++;
        if (obs_vec !== exp_vec()) begin
          n_errors++;
          $display("FAIL wrap_model p=%0d i=%0d: got %h expected %h", p, i, obs_vec, exp_vec());
        end
      end
      n_checks++;
      if ({x16, x10, y16, y10} !== {4'(ex16[p]), 4'(ex10[p]), 4'(ey16[p]), 4'(ey10[p])}) begin
        n_errors++;
        $display("FAIL wrap_coord p=%0d: x16=%0d x10=%0d y16=%0d y10=%0d expected %0d %0d %0d %0d",
                 p, x16, x10, y16, y10, ex16[p], ex10[p], ey16[p], ey10[p]);
      end
    end
  endtask

  task automatic test_glitch();
    int c = 0;
    int saw_open = 0;
    int x0 = mx[0];
    int y0 = my[0];
    bit v = 0;
    while (c < 50) begin
      int run = $urandom_range(1, 3);
      v = !v;
      for (int r = 0; r < run && c < 50; r++) begin
        btn_open = (c < 40) ? v : 1'b0;
        cycle();
        saw_open += int'(open16) + int'(open10);
        n_checks++;
        if (obs_vec !== exp_vec()) begin
          n_errors++;
          $display("FAIL glitch_model c=%0d: got %h expected %h", c, obs_vec, exp_vec());
        end
        c++;
      end
    end
    btn_open = 1'b0;
    n_checks++;
    if (saw_open != 0 || x16 !== 4'(x0) || y16 !== 4'(y0)) begin
      n_errors++;
      $display("FAIL glitch_result: opens=%0d x=%0d y=%0d expected 0 opens x=%0d y=%0d",
               saw_open, x16, y16, x0, y0);
    end
  endtask

  task automatic test_holdoff();
    int  x0 = mx[0];
    int  fl = 0, op = 0, bz = 0;
    bit  found = 0;
    set_btns(6'b110000);
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL holdoff_wait i=%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
      op += int'(open16);
      if (flag16) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL holdoff_pulse: no flag pulse within 20 cycles, required one");
    end
    for (int c = 0; c < 300; c++) begin
      fl += int'(flag16);
      op += int'(open16);
      bz += int'(busy16);
      if (c == 200) begin
        n_checks++;
        if (x16 !== 4'(x0)) begin
          n_errors++;
          $display("FAIL holdoff_ignore: x got %0d expected %0d", x16, x0);
        end
      end
      if (c == 5) begin
        btn_flag = 1'b0;
        btn_open = 1'b0;
      end
      btn_right = ((c >= 93 && c < 103) || (c >= 253 && c < 263));
      cycle();
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL holdoff_model c=%0d: got %h expected %h", c, obs_vec, exp_vec());
      end
    end
    n_checks++;
    if (fl != 1 || op != 0 || bz != HOLD || x16 !== 4'((x0 + 1) % 16)) begin
      n_errors++;
      $display("FAIL holdoff_summary: flags=%0d opens=%0d busy=%0d x=%0d expected 1 0 %0d x=%0d",
               fl, op, bz, x16, HOLD, (x0 + 1) % 16);
    end
  endtask

  task automatic test_lock();
    int y0 = my[0];
    int saw_open = 0, saw_busy = 0;
    lock = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_btns(i < 10 ? 6'b100000 : ((i >= 20 && i < 30) ? 6'b000010 : 6'b0));
      cycle();
      saw_open += int'(open16);
      saw_busy += int'(busy16);
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL lock_model i=%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
    end
    lock = 1'b0;
    n_checks++;
    if (saw_open != 0 || saw_busy != 0 || y16 !== 4'((y0 + 1) % 16)) begin
      n_errors++;
      $display("FAIL lock_result: opens=%0d busy=%0d y=%0d expected 0 0 y=%0d",
               saw_open, saw_busy, y16, (y0 + 1) % 16);
    end
  endtask

  task automatic test_async_reset();
    int  moves = 0;
    bit  found = 0;
    logic [3:0] prev_y;
    // mid-debounce of up
    btn_up = 1'b1;
    repeat (3) cycle();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs_vec !== 22'd0) begin
      n_errors++;
      $display("FAIL async_rst_debounce: got %h expected %h", obs_vec, 22'd0);
    end
    btn_up = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_checks++;
      if (obs_vec !== exp_vec() || y16 !== 4'd0) begin
        n_errors++;
        $display("FAIL async_rst_nomove i=%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
    end
    // during hold-off
    btn_flag = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (busy16) found = 1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL async_rst_busy: busy not seen within 20 cycles, required 1");
    end
    btn_flag = 1'b0;
    repeat (3) cycle();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs_vec !== 22'd0) begin
      n_errors++;
      $display("FAIL async_rst_holdoff: got %h expected %h", obs_vec, 22'd0);
    end
    // up held through reset release
    btn_up = 1'b1;
    repeat (3) cycle();
    reset = 1'b0;
    prev_y = 4'd0;
    for (int i = 0; i < 30; i++) begin
      if (i == 20) btn_up = 1'b0;
      cycle();
      if (y16 !== prev_y) moves++;
      prev_y = y16;
      n_checks++;
      if (obs_vec !== exp_vec()) begin
        n_errors++;
        $display("FAIL async_rst_held i=%0d: got %h expected %h", i, obs_vec, exp_vec());
      end
    end
    n_checks++;
    if (moves != 1 || y16 !== 4'd15 || y10 !== 4'd9) begin
      n_errors++;
      $display("FAIL async_rst_onemove: moves=%0d y16=%0d y10=%0d expected 1 15 9", moves, y16, y10);
    end
  endtask

  task automatic test_random();
    int c = 0;
    while (c < 1500) begin
      bit [5:0] m = 6'($urandom_range(0, 15));
      int len = $urandom_range(1, 12);
      if ($urandom_range(0, 7) == 0) m[5:4] = 2'($urandom_range(1, 3));
      lock = ($urandom_range(0, 9) == 0);
      set_btns(m);
      for (int r = 0; r < len; r++) begin
        cycle();
        n_checks++;
        if (obs_vec !== exp_vec()) begin
          n_errors++;
          $display("FAIL random_model c=%0d: got %h expected %h", c, obs_vec, exp_vec());
        end
        c++;
      end
    end
    set_btns(6'b0);
    lock = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    lock  = 1'b0;
    set_btns(6'b0);
    model_reset();
    test_reset();
    test_press_latency();
    test_wrap();
    test_glitch();
    test_holdoff();
    test_lock();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
